// File: rtl/sp_ram_ctl.sv
// Single-port synchronous RAM with configurable read latency, write-collision mode
// and a hardware clear engine that fills the array with CLEAR_VAL.
module sp_ram_ctl #(
  parameter int unsigned       DATA_W     = 9,
  parameter int unsigned       ADDR_W     = 6,
  parameter int unsigned       READ_MODE  = 0,
  parameter int unsigned       WRITE_MODE = 0,
  parameter bit                INIT_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic              busy,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam state_e ResetState = INIT_CLEAR ? StClear : StIdle;

  if (READ_MODE > 1) begin : gen_bad_read_mode
    $error("sp_ram_ctl: READ_MODE must be 0 or 1");
  end
  if (WRITE_MODE > 2) begin : gen_bad_write_mode
    $error("sp_ram_ctl: WRITE_MODE must be 0, 1 or 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  assign rd_word = mem[ad];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    out_d     = out_q;
    mem_we    = 1'b0;
    mem_addr  = ad;
    mem_wdata = din;
    unique case (state_q)
      StIdle: begin
        if (ce) begin
          if (wre) begin
            mem_we = 1'b1;
            // Old word comes from the pre-write array value (read-before-write).
            if (WRITE_MODE == 1) begin
              data_d = din;
            end else if (WRITE_MODE == 2) begin
              data_d = rd_word;
            end
          end else begin
            data_d = rd_word;
          end
        end
        if (oce) begin
          out_d = data_q;
        end
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // User inputs are ignored; data and output registers hold.
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = CLEAR_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign busy = (state_q == StClear);
  assign dout = (READ_MODE == 1) ? out_q : data_q;

endmodule

// File: tb/tb_sp_ram_ctl.sv
// Scoreboard bench for sp_ram_ctl: four instances cover write modes 0/1/2 (bypass read)
// and pipelined read, all sharing one stimulus stream.
module tb_sp_ram_ctl;

  localparam int DW    = 9;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce, oce, wre, clr;
  logic [AW-1:0] ad;
  logic [DW-1:0] din;
  logic          busy0, busy1, busy2, busy3;
  logic [DW-1:0] dout0, dout1, dout2, dout3;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp3_q[$];

  always #5 clk = ~clk;

  sp_ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .WRITE_MODE(0), .INIT_CLEAR(1'b1),
               .CLEAR_VAL(9'h000)) u_wm0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .busy(busy0), .dout(dout0));

  sp_ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .WRITE_MODE(1), .INIT_CLEAR(1'b1),
               .CLEAR_VAL(9'h000)) u_wm1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .busy(busy1), .dout(dout1));

  sp_ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .WRITE_MODE(2), .INIT_CLEAR(1'b1),
               .CLEAR_VAL(9'h000)) u_wm2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .busy(busy2), .dout(dout2));

  sp_ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(1), .WRITE_MODE(0), .INIT_CLEAR(1'b1),
               .CLEAR_VAL(9'h000)) u_rm1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .busy(busy3), .dout(dout3));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ce = 1'b1; wre = 1'b1; ad = a; din = d;
    model[a] = d;
    cyc();
    ce = 1'b0; wre = 1'b0;
  endtask

  task automatic read_check(input logic [AW-1:0] a);
    logic [DW-1:0] e;
    ce = 1'b1; wre = 1'b0; ad = a;
    exp_q.push_back(model[a]);
    cyc();
    ce = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (dout0 !== e) begin
      errors++;
      $display("FAIL read_bypass addr %0d: got %h expected %h", a, dout0, e);
    end
  endtask

  // Bounded busy-length measurement; first sample is taken before any clear edge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      cyc();
    end
  endtask

  task automatic read_all(input string tag);
    logic [DW-1:0] e;
    oce = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      ce = 1'b1; wre = 1'b0; ad = AW'(a);
      exp_q.push_back(model[a]);
      exp3_q.push_back(model[a]);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (dout0 !== e) begin
        errors++;
        $display("FAIL %s bypass addr %0d: got %h expected %h", tag, a, dout0, e);
      end
      if (exp3_q.size() == 2) begin
        e = exp3_q.pop_front();
        checks++;
        if (dout3 !== e) begin
          errors++;
          $display("FAIL %s pipelined addr %0d: got %h expected %h", tag, a - 1, dout3, e);
        end
      end
    end
    ce = 1'b0;
    cyc();
    e = exp3_q.pop_front();
    checks++;
    if (dout3 !== e) begin
      errors++;
      $display("FAIL %s pipelined last: got %h expected %h", tag, dout3, e);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce = 1'b0; oce = 1'b1; wre = 1'b0; clr = 1'b0; ad = '0; din = '0;
    clear_model();
    repeat (3) cyc();
    checks++;
    if (busy0 !== 1'b1 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b expected 1/1", busy0, busy3);
    end
    checks++;
    if ({dout0, dout1, dout2, dout3} !== '0) begin
      errors++;
      $display("FAIL reset_dout: got %h %h %h %h expected 0", dout0, dout1, dout2, dout3);
    end
  endtask

  task automatic test_init_clear();
    int n;
    reset_n = 1'b1;
    count_busy(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL init_clear_len: got %0d expected %0d", n, DEPTH);
    end
    checks++;
    if (busy3 !== 1'b0) begin
      errors++;
      $display("FAIL init_clear_busy_rm1: got %b expected 0", busy3);
    end
    read_all("init_clear");
  endtask

  task automatic test_read_bypass();
    write_word(6'd5, 9'h1A5);
    read_check(6'd5);
    ce = 1'b0;
    ad = 6'd0;
    cyc();
    checks++;
    if (dout0 !== 9'h1A5) begin
      errors++;
      $display("FAIL ce_low_hold: got %h expected 1a5", dout0);
    end
  endtask

  task automatic test_write_modes();
    write_word(6'd3, 9'h055);
    read_check(6'd5);
    checks++;
    if (dout1 !== 9'h1A5 || dout2 !== 9'h1A5) begin
      errors++;
      $display("FAIL wm_preload: got %h/%h expected 1a5/1a5", dout1, dout2);
    end
    write_word(6'd3, 9'h0AA);
    checks++;
    if (dout0 !== 9'h1A5) begin
      errors++;
      $display("FAIL wm0_hold: got %h expected 1a5", dout0);
    end
    checks++;
    if (dout1 !== 9'h0AA) begin
      errors++;
      $display("FAIL wm1_through: got %h expected 0aa", dout1);
    end
    checks++;
    if (dout2 !== 9'h055) begin
      errors++;
      $display("FAIL wm2_old: got %h expected 055", dout2);
    end
    read_check(6'd3);
  endtask

  task automatic test_read_pipelined();
    write_word(6'd9, 9'h123);
    oce = 1'b1; ce = 1'b1; wre = 1'b0; ad = 6'd9;
    cyc();
    ce = 1'b0;
    cyc();
    checks++;
    if (dout3 !== 9'h123) begin
      errors++;
      $display("FAIL pipe_oce1: got %h expected 123", dout3);
    end
    oce = 1'b0; ce = 1'b1; ad = 6'd5;
    cyc();
    ce = 1'b0;
    cyc();
    checks++;
    if (dout3 !== 9'h123) begin
      errors++;
      $display("FAIL pipe_oce0_hold: got %h expected 123", dout3);
    end
    oce = 1'b1;
    cyc();
    checks++;
    if (dout3 !== 9'h1A5) begin
      errors++;
      $display("FAIL pipe_oce_release: got %h expected 1a5", dout3);
    end
  endtask

  task automatic test_clear_request();
    int n;
    write_word(6'd40, 9'h0F0);
    read_check(6'd5);
    // The access in the clr cycle still executes, but is then cleared.
    clr = 1'b1; ce = 1'b1; wre = 1'b1; ad = 6'd10; din = 9'h0FF;
    cyc();
    clr = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      ce = 1'b1; wre = 1'b1; ad = AW'(n * 7); din = DW'($urandom);
      clr = (n == 30);
      cyc();
    end
    ce = 1'b0; wre = 1'b0; clr = 1'b0;
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clr_len: got %0d expected %0d", n, DEPTH);
    end
    checks++;
    if (dout0 !== 9'h1A5) begin
      errors++;
      $display("FAIL clr_dout_hold: got %h expected 1a5", dout0);
    end
    clear_model();
    read_all("clr_request");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    write_word(6'd60, 9'h111);
    write_word(6'd5, 9'h1A5);
    read_check(6'd5);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (20) cyc();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dout0, dout1, dout2, dout3} !== '0) begin
      errors++;
      $display("FAIL mid_reset_dout: got %h %h %h %h expected 0", dout0, dout1, dout2, dout3);
    end
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_busy: got %b expected 1", busy0);
    end
    repeat (2) cyc();
    reset_n = 1'b1;
    count_busy(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL mid_reset_len: got %0d expected %0d", n, DEPTH);
    end
    clear_model();
    read_all("mid_reset");
  endtask

  initial begin
    test_reset();
    test_init_clear();
    test_read_bypass();
    test_write_modes();
    test_read_pipelined();
    test_clear_request();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
